// File: rtl/repeat_run_pkg.sv
// Package: repeat_run_pkg
// Shared definitions for the repeat run tracker.
//  - state_e         : tracker FSM encoding (IDLE / ARMED / RUN), 2 bits
//  - DEF_MIN_CTR_VAL : counter value while armed with no repeats seen yet
//  - Record layout   : the record slot carries one packed word laid out as
//                      {id, addr, count}, most significant field first.
//                      REC_FIELDS names the number of fields in that word.
package repeat_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int DEF_MIN_CTR_VAL = 2;
  localparam int REC_FIELDS      = 3;

endpackage

// File: rtl/repeat_rec_slot.sv
// Module: repeat_rec_slot
// One-deep holding register for run records with a valid/ready output port
// and a sticky overflow flag.
// Ports:
//  clk       in   1       system clock
//  reset     in   1       synchronous, active-high reset
//  load      in   1       a new record is offered this cycle
//  load_data in   DATA_W  record offered with load
//  ready     in   1       downstream accepts the held record
//  valid     out  1       a record is held
//  data      out  DATA_W  held record, stable while valid & ~ready
//  overflow  out  1       sticky: an offered record was dropped
module repeat_rec_slot
  import repeat_run_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              overflow
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic              overflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      overflow_reg <= 1'b0;
    end else if (load) begin
      // A stalled record keeps priority; the newcomer is lost and flagged.
      // If the held record leaves this same cycle, the new one replaces it.
      if (valid_reg && !ready) begin
        overflow_reg <= 1'b1;
      end else begin
        data_reg  <= load_data;
        valid_reg <= 1'b1;
      end
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid    = valid_reg;
  assign data     = data_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/repeat_run_tracker.sv
// Module: repeat_run_tracker
// Watches speculated-block hits (id + address) and detects runs of repeats:
// a hit repeats when it carries the reference id at reference address plus
// ADDR_STRIDE. Counts the run length and, when the run closes, emits a
// {id, addr, count} record over a valid/ready port.
// Ports:
//  clk            in   1       system clock
//  reset          in   1       synchronous, active-high reset
//  detect_mux     in   1       speculated-block hit this cycle
//  active_addr    in   ADDR_W  address of hit block
//  active_id      in   ID_W    id of hit block
//  flush          in   1       close any open run, return to IDLE
//  rec_ready      in   1       downstream accepts run record
//  last_spec_addr out  ADDR_W  held reference address
//  first_repeat   out  1       hit is first repeat of run (combinational)
//  subseq_repeat  out  1       hit is 2nd+ repeat of run (combinational)
//  repeat_spec    out  1       detect_mux & (first_repeat | subseq_repeat)
//  repeat_ctr     out  CTR_W   registered run counter
//  rec_valid      out  1       run record pending
//  rec_id         out  ID_W    record: block id
//  rec_addr       out  ADDR_W  record: reference address
//  rec_count      out  CTR_W   record: repeats in run
//  rec_overflow   out  1       sticky: a record was dropped
module repeat_run_tracker
  import repeat_run_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int ID_W        = 8,
  parameter int CTR_W       = 32,
  parameter int ADDR_STRIDE = 2,
  parameter int MIN_CTR_VAL = DEF_MIN_CTR_VAL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              detect_mux,
  input  logic [ADDR_W-1:0] active_addr,
  input  logic [ID_W-1:0]   active_id,
  input  logic              flush,
  input  logic              rec_ready,
  output logic [ADDR_W-1:0] last_spec_addr,
  output logic              first_repeat,
  output logic              subseq_repeat,
  output logic              repeat_spec,
  output logic [CTR_W-1:0]  repeat_ctr,
  output logic              rec_valid,
  output logic [ID_W-1:0]   rec_id,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [CTR_W-1:0]  rec_count,
  output logic              rec_overflow
);

  localparam int               REC_W    = ID_W + ADDR_W + CTR_W;
  localparam logic [CTR_W-1:0] CTR_MIN  = CTR_W'(MIN_CTR_VAL);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(ADDR_STRIDE);

  state_e             state_reg, state_next;
  logic [ADDR_W-1:0]  last_addr_reg, last_addr_next;
  logic [ID_W-1:0]    last_id_reg, last_id_next;
  logic [CTR_W-1:0]   ctr_reg, ctr_next;
  logic               close_run;
  logic [ADDR_W-1:0]  stride_addr;
  logic               match;
  logic [REC_W-1:0]   rec_word;
  logic [REC_W-1:0]   rec_data;

  // Address compare is modulo 2**ADDR_W, so FFFE -> 0000 counts as a stride.
  assign stride_addr = last_addr_reg + STRIDE;
  assign match       = (stride_addr == active_addr) && (last_id_reg == active_id);

  assign first_repeat  = (state_reg == ST_ARMED) && match;
  assign subseq_repeat = (state_reg == ST_RUN) && match;
  assign repeat_spec   = detect_mux && (first_repeat || subseq_repeat);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      last_addr_reg <= '0;
      last_id_reg   <= '0;
      ctr_reg       <= CTR_MIN;
    end else begin
      state_reg     <= state_next;
      last_addr_reg <= last_addr_next;
      last_id_reg   <= last_id_next;
      ctr_reg       <= ctr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_addr_next = last_addr_reg;
    last_id_next   = last_id_reg;
    ctr_next       = ctr_reg;
    close_run      = 1'b0;

    if (flush) begin
      // Flush wins over a simultaneous hit; the hit is not observed.
      close_run  = (state_reg == ST_RUN);
      state_next = ST_IDLE;
      ctr_next   = CTR_MIN;
    end else if (detect_mux) begin
      unique case (state_reg)
        ST_IDLE: begin
          last_addr_next = active_addr;
          last_id_next   = active_id;
          state_next     = ST_ARMED;
          ctr_next       = CTR_MIN;
        end
        ST_ARMED: begin
          // On a match the reference stays at the run's base address, so
          // every later repeat must hit the same base+stride address.
          if (match) begin
            state_next = ST_RUN;
            ctr_next   = CTR_MIN + CTR_ONE;
          end else begin
            last_addr_next = active_addr;
            last_id_next   = active_id;
            ctr_next       = CTR_MIN;
          end
        end
        ST_RUN: begin
          if (match) begin
            if (ctr_reg == CTR_MAX) begin
              // Saturated: report the run and re-arm on the same reference.
              close_run  = 1'b1;
              state_next = ST_ARMED;
              ctr_next   = CTR_MIN;
            end else begin
              ctr_next = ctr_reg + CTR_ONE;
            end
          end else begin
            close_run      = 1'b1;
            last_addr_next = active_addr;
            last_id_next   = active_id;
            state_next     = ST_ARMED;
            ctr_next       = CTR_MIN;
          end
        end
        default: begin
          state_next = ST_IDLE;
          ctr_next   = CTR_MIN;
        end
      endcase
    end
  end

  // The closing record describes the run that just ended, i.e. the
  // reference and count as they stand before this edge.
  assign rec_word = {last_id_reg, last_addr_reg, ctr_reg - CTR_MIN};

  repeat_rec_slot #(
    .DATA_W (REC_W)
  ) u_rec_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (close_run),
    .load_data (rec_word),
    .ready     (rec_ready),
    .valid     (rec_valid),
    .data      (rec_data),
    .overflow  (rec_overflow)
  );

  assign {rec_id, rec_addr, rec_count} = rec_data;

  assign last_spec_addr = last_addr_reg;
  assign repeat_ctr     = ctr_reg;

endmodule

// File: tb/tb_repeat_run_tracker.sv
// Bench for repeat_run_tracker: two instances (32-bit and 3-bit counter)
// share one directed stimulus stream. A run-length model checks every
// output of both instances on every falling edge; a set of hand-computed
// literals pins the model at key points of each scenario.
module tb_repeat_run_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        detect_mux = 1'b0;
  logic [15:0] active_addr = '0;
  logic [7:0]  active_id = '0;
  logic        flush = 1'b0;
  logic        rec_ready = 1'b1;

  logic [15:0] a_last, b_last;
  logic        a_first, b_first, a_subseq, b_subseq, a_spec, b_spec;
  logic [31:0] a_ctr;
  logic [2:0]  b_ctr;
  logic        a_rv, b_rv, a_ovf, b_ovf;
  logic [7:0]  a_rid, b_rid;
  logic [15:0] a_raddr, b_raddr;
  logic [31:0] a_rcnt;
  logic [2:0]  b_rcnt;

  repeat_run_tracker u_dut_a (
    .clk(clk), .reset(reset), .detect_mux(detect_mux), .active_addr(active_addr),
    .active_id(active_id), .flush(flush), .rec_ready(rec_ready),
    .last_spec_addr(a_last), .first_repeat(a_first), .subseq_repeat(a_subseq),
    .repeat_spec(a_spec), .repeat_ctr(a_ctr), .rec_valid(a_rv), .rec_id(a_rid),
    .rec_addr(a_raddr), .rec_count(a_rcnt), .rec_overflow(a_ovf)
  );

  repeat_run_tracker #(.CTR_W(3)) u_dut_b (
    .clk(clk), .reset(reset), .detect_mux(detect_mux), .active_addr(active_addr),
    .active_id(active_id), .flush(flush), .rec_ready(rec_ready),
    .last_spec_addr(b_last), .first_repeat(b_first), .subseq_repeat(b_subseq),
    .repeat_spec(b_spec), .repeat_ctr(b_ctr), .rec_valid(b_rv), .rec_id(b_rid),
    .rec_addr(b_raddr), .rec_count(b_rcnt), .rec_overflow(b_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;
  bit rdy_cur = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- run-length model ----------------
  // tracking: a reference is held (not idle); run_len: repeats seen in the
  // open run (0 = none). Expected counter is MIN + run_len.
  bit          m_track[2];
  longint      m_run[2];
  logic [15:0] m_ref_addr[2];
  logic [7:0]  m_ref_id[2];
  bit          m_pend[2];
  logic [7:0]  m_rid[2];
  logic [15:0] m_raddr[2];
  longint      m_rcnt[2];
  bit          m_ovf[2];
  longint      m_max[2] = '{64'd4294967295, 64'd7};

  function automatic bit model_match(input int k);
    logic [15:0] nxt;
    nxt = m_ref_addr[k] + 16'd2;
    return (nxt == active_addr) && (m_ref_id[k] == active_id);
  endfunction

  task automatic model_step(input int k);
    bit m, close, had_rec;
    longint cnt;
    logic [7:0] cid;
    logic [15:0] caddr;
    if (reset) begin
      m_track[k] = 0; m_run[k] = 0; m_ref_addr[k] = '0; m_ref_id[k] = '0;
      m_pend[k] = 0; m_rid[k] = '0; m_raddr[k] = '0; m_rcnt[k] = 0; m_ovf[k] = 0;
      return;
    end
    m = m_track[k] && model_match(k);
    close = 0; cnt = 0; cid = m_ref_id[k]; caddr = m_ref_addr[k];
    if (flush) begin
      if (m_run[k] > 0) begin close = 1; cnt = m_run[k]; end
      m_track[k] = 0; m_run[k] = 0;
    end else if (detect_mux) begin
      if (!m_track[k]) begin
        m_track[k] = 1; m_ref_addr[k] = active_addr; m_ref_id[k] = active_id;
      end else if (m_run[k] == 0) begin
        if (m) m_run[k] = 1;
        else begin m_ref_addr[k] = active_addr; m_ref_id[k] = active_id; end
      end else if (m) begin
        if (2 + m_run[k] == m_max[k]) begin close = 1; cnt = m_run[k]; m_run[k] = 0; end
        else m_run[k]++;
      end else begin
        close = 1; cnt = m_run[k]; m_run[k] = 0;
        m_ref_addr[k] = active_addr; m_ref_id[k] = active_id;
      end
    end
    had_rec = m_pend[k];
    if (close) begin
      if (had_rec && !rec_ready) m_ovf[k] = 1;
      else begin m_pend[k] = 1; m_rid[k] = cid; m_raddr[k] = caddr; m_rcnt[k] = cnt; end
    end else if (had_rec && rec_ready) begin
      m_pend[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp_inst(input int k, input string p, input logic [15:0] last,
                          input logic first, input logic subseq, input logic spec,
                          input longint ctr, input logic rv, input logic [7:0] rid,
                          input logic [15:0] raddr, input longint rcnt, input logic ovf);
    bit m, e_first, e_subseq;
    m = model_match(k);
    e_first  = m_track[k] && (m_run[k] == 0) && m;
    e_subseq = (m_run[k] > 0) && m;
    chk({p, "last_spec_addr"}, last, m_ref_addr[k]);
    chk({p, "first_repeat"}, first, e_first);
    chk({p, "subseq_repeat"}, subseq, e_subseq);
    chk({p, "repeat_spec"}, spec, detect_mux && (e_first || e_subseq));
    chk({p, "repeat_ctr"}, ctr, 2 + m_run[k]);
    chk({p, "rec_valid"}, rv, m_pend[k]);
    chk({p, "rec_id"}, rid, m_rid[k]);
    chk({p, "rec_addr"}, raddr, m_raddr[k]);
    chk({p, "rec_count"}, rcnt, m_rcnt[k]);
    chk({p, "rec_overflow"}, ovf, m_ovf[k]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, "A.", a_last, a_first, a_subseq, a_spec, a_ctr, a_rv, a_rid, a_raddr, a_rcnt, a_ovf);
      cmp_inst(1, "B.", b_last, b_first, b_subseq, b_spec, longint'(b_ctr), b_rv, b_rid, b_raddr,
               longint'(b_rcnt), b_ovf);
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after the rising edge; literal checks run
  // 3 units after the edge (registered state from that edge, comb outputs
  // for the inputs just applied).
  task automatic cyc(input bit d, input logic [7:0] id, input logic [15:0] a,
                     input bit f, input bit rs);
    @(posedge clk);
    #1;
    detect_mux = d; active_id = id; active_addr = a; flush = f;
    rec_ready = rdy_cur; reset = rs;
    #2;
    $display("cyc t=%0t det=%0b id=%0h addr=%04h flush=%0b rdy=%0b rst=%0b",
             $time, d, id, a, f, rdy_cur, rs);
  endtask

  task automatic hit(input logic [7:0] id, input logic [15:0] a);
    cyc(1'b1, id, a, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1'b0, 8'h0, 16'h0, 1'b0, 1'b1);
    cyc(1'b0, 8'h0, 16'h0, 1'b0, 1'b1);
    cmp_en = 1'b1;
    idle();
    chk("reset_ctr", a_ctr, 2);
    chk("reset_rec_valid", a_rv, 0);
    chk("reset_last_addr", a_last, 0);

    // 1: run of three repeats closed by a different block
    hit(8'd5, 16'h0100);
    chk("t1_arm_first", a_first, 0);
    hit(8'd5, 16'h0102);
    chk("t1_first", a_first, 1);
    hit(8'd5, 16'h0102);
    chk("t1_subseq3", a_subseq, 1);
    hit(8'd5, 16'h0102);
    chk("t1_subseq4", a_subseq, 1);
    chk("t1_ctr4", a_ctr, 4);
    hit(8'd7, 16'h0200);
    idle();
    chk("t1_rec_valid", a_rv, 1);
    chk("t1_rec_id", a_rid, 5);
    chk("t1_rec_addr", a_raddr, 16'h0100);
    chk("t1_rec_count", a_rcnt, 3);
    chk("t1_ctr_after", a_ctr, 2);
    idle();
    chk("t1_rec_gone", a_rv, 0);

    // 2: id mismatch at stride address: no repeat, reference moves
    hit(8'd5, 16'h0100);
    hit(8'd6, 16'h0102);
    chk("t2_no_first", a_first, 0);
    idle();
    chk("t2_ref", a_last, 16'h0102);
    chk("t2_ctr", a_ctr, 2);
    chk("t2_no_rec", a_rv, 0);

    // 3: saturation on the 3-bit instance
    for (int i = 0; i < 6; i++) hit(8'd6, 16'h0104);
    hit(8'd6, 16'h0104);
    chk("t3_b_first_again", b_first, 1);
    chk("t3_b_rec_valid", b_rv, 1);
    chk("t3_b_rec_count", b_rcnt, 5);
    chk("t3_a_subseq", a_subseq, 1);
    chk("t3_a_ctr", a_ctr, 8);
    hit(8'd9, 16'h0300);
    idle();
    chk("t3_a_rec_count", a_rcnt, 7);
    idle();

    // 4: backpressure, second record dropped
    rdy_cur = 1'b0;
    hit(8'd1, 16'h0010);
    hit(8'd1, 16'h0012);
    hit(8'd2, 16'h0020);
    hit(8'd2, 16'h0022);
    hit(8'd3, 16'h0030);
    idle();
    chk("t4_rec_valid", a_rv, 1);
    chk("t4_rec_addr", a_raddr, 16'h0010);
    chk("t4_rec_count", a_rcnt, 1);
    chk("t4_overflow", a_ovf, 1);
    idle();
    chk("t4_rec_stable", a_rid, 1);
    rdy_cur = 1'b1;
    idle();
    idle();
    chk("t4_overflow_sticky", a_ovf, 1);

    // 5: flush together with a hit
    hit(8'd3, 16'h0032);
    hit(8'd3, 16'h0032);
    cyc(1'b1, 8'd3, 16'h0032, 1'b1, 1'b0);
    idle();
    chk("t5_rec_valid", a_rv, 1);
    chk("t5_rec_addr", a_raddr, 16'h0030);
    chk("t5_rec_count", a_rcnt, 2);
    chk("t5_ctr", a_ctr, 2);
    hit(8'd3, 16'h0032);
    chk("t5_idle_no_first", a_first, 0);
    chk("t5_idle_no_spec", a_spec, 0);
    hit(8'd3, 16'h0034);
    chk("t5_rearmed_first", a_first, 1);

    // 6: reset in RUN with a pending record, then address wrap
    rdy_cur = 1'b0;
    hit(8'd4, 16'h0040);
    hit(8'd4, 16'h0042);
    chk("t6_pending", a_rv, 1);
    cyc(1'b0, 8'h0, 16'h0, 1'b0, 1'b1);
    rdy_cur = 1'b1;
    idle();
    chk("t6_rst_rv", a_rv, 0);
    chk("t6_rst_ovf", a_ovf, 0);
    chk("t6_rst_ctr", a_ctr, 2);
    chk("t6_rst_last", a_last, 0);
    chk("t6_rst_rcnt", a_rcnt, 0);
    hit(8'd1, 16'hFFFE);
    hit(8'd1, 16'h0000);
    chk("t6_wrap_first", a_first, 1);
    hit(8'd1, 16'h0000);
    chk("t6_wrap_subseq", a_subseq, 1);
    hit(8'd2, 16'h0000);
    idle();
    chk("t6_wrap_rec_addr", a_raddr, 16'hFFFE);
    chk("t6_wrap_rec_count", a_rcnt, 2);
    idle();

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
